instr_prefetch_unit: RTL and testbench
======================================

// Module: instr_prefetch_unit
// PURPOSE
//  Upstream of decode: fetches instructions from instruction memory over a valid/ready
//  request + in-order response bus and buffers them in a DEPTH-entry prefetch queue.
//  Presents komut/pc to decode with a valid/ready handshake and honours pc_update/pc_new
//  redirects from execute. Raises the sticky hata on a fetch fault.
// PARAMETERS
//  DEPTH     4             queue entries and max outstanding requests (power of 2, >=2)
//  RESET_PC  32'h0000_0000 first fetch address after reset
// PORTS
//  clk            in   1   single clock, rising edge
//  reset          in   1   synchronous, active-low (0 = reset)
//  imem_req_valid out  1   request valid
//  imem_req_ready in   1   memory accepts request
//  imem_req_addr  out  32  word-aligned fetch address
//  imem_rsp_valid in   1   response valid (in order, one per accepted request)
//  imem_rsp_data  in   32  instruction word
//  imem_rsp_err   in   1   bus error for this response
//  komut          out  32  instruction at queue head
//  pc             out  32  address of komut
//  komut_valid    out  1   head entry valid
//  komut_ready    in   1   decode consumes head
//  pc_update      in   1   redirect request from execute
//  pc_new         in   32  redirect target
//  hata           out  1   sticky fetch fault
// BEHAVIOUR
//  Reset (reset=0 at edge): fpc<=RESET_PC, queue empty, outstanding=0, drop=0, state RUN.
//   All outputs 0 except imem_req_addr=RESET_PC. Imem is reset by the same reset.
//  Request issue: imem_req_valid=1 when state==RUN and (count+outstanding) < DEPTH.
//   Once asserted, valid and addr hold stable until imem_req_ready. Accept = valid&ready:
//   outstanding++, fpc<=fpc+4 (mod 2^32, 0xFFFF_FFFC wraps to 0).
//  Response: each imem_rsp_valid decrements outstanding. If drop>0: discard, drop--.
//   Else push {err,addr,data}. addr comes from an internal in-order address tag queue.
//   komut_valid rises the cycle after the push; no bypass (1-cycle registered latency).
//  Dequeue: komut_valid&komut_ready pops the head. Push and pop in the same cycle keep count.
//  Redirect (pc_update=1): queue flushed the next cycle (komut_valid=0);
//   drop<=outstanding-after-this-cycle, so in-flight responses are discarded; fpc<=pc_new.
//   A stalled request (valid&!ready) stays stable until accepted and its response is dropped.
//   New-target fetch starts after that request is accepted.
//   Redirect beats a same-cycle response, which is dropped. Redirect beats a same-cycle pop,
//   and the pop still counts as consumed.
//  Errors -> state HALT, hata<=1 the next cycle, sticky until reset:
//   pc_new[1:0]!=0 on redirect; queue head with err=1 (komut_valid=0 for it).
//   In HALT: no new requests, komut_valid=0, responses still counted and discarded.
//  FSM: RUN -(fault)-> HALT; HALT -(reset only)-> RUN.
//  Invariant: count+outstanding <= DEPTH; count never exceeds DEPTH (no overflow possible).
// STRUCTURE
//  fetch_pkg:
//   fetch_state_t {RUN,HALT}
//   fetch_entry_t {logic err; logic [31:0] addr, instr;}
//   RESET_PC default, INSTR_BYTES=4
//  Sub-module: sync_fifo #(WIDTH,DEPTH) with push/pop/flush/full/empty/count.
//   Used for the prefetch queue and the address tag queue.
//  Top level: fpc register, outstanding/drop counters, FSM, handshake glue.
// TESTING
//  1 reset=0 for 3 cycles -> all valid outputs 0, hata=0. First cycle after release:
//    imem_req_valid=1, addr=0x0.
//  2 Ready memory, 1-cycle latency, komut_ready=1, data=0x00000013 -> komut_valid from
//    cycle 3, pc 0x0,0x4,0x8... one per cycle, no gaps.
//  3 komut_ready=0 -> exactly 4 requests issued, then imem_req_valid=0. Releasing
//    komut_ready -> pcs 0x0..0xC in order, fetch resumes at 0x10.
//  4 Two requests in flight, pc_update=1, pc_new=0x100 -> komut_valid=0 next cycle,
//    2 stale responses dropped, next delivered pc=0x100.
//  5 pc_new=0x102 with pc_update -> hata=1 next cycle, no further requests,
//    komut_valid stays 0 until reset.
//  6 imem_rsp_err=1 on the fetch of 0x8 -> 0x0 and 0x4 delivered, then hata=1 with
//    komut_valid=0. Redirect/fpc wrap at 0xFFFF_FFFC -> next addr 0x0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction prefetch unit.
package fetch_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] INSTR_BYTES      = 32'd4;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic        err;
        logic [31:0] addr;
        logic [31:0] instr;
    } fetch_entry_t;

    function automatic logic misaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/instr_prefetch_unit_sync_fifo.sv
// Synchronous FIFO with flush, used for the prefetch queue and the address tag queue.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_push,
    input  logic                   i_pop,
    input  logic                   i_flush,
    input  logic [WIDTH-1:0]       i_data,
    output logic [WIDTH-1:0]       o_data,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic [PW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == (PW+1)'(DEPTH));
    assign o_empty = (r_count == {(PW+1){1'b0}});
    assign o_count = r_count;
    assign o_data  = r_mem[r_rptr];
    assign w_pop   = i_pop && !o_empty;
    assign w_push  = i_push && (!o_full || w_pop);

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (reset && !i_flush && w_push) begin
            r_mem[r_wptr] <= i_data;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clk) begin
        if (!reset || i_flush) begin
            r_wptr  <= {PW{1'b0}};
            r_rptr  <= {PW{1'b0}};
            r_count <= {(PW+1){1'b0}};
        end else begin
            if (w_push) r_wptr <= r_wptr + PW'(1);
            if (w_pop)  r_rptr <= r_rptr + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PW+1)'(1);
                2'b01:   r_count <= r_count - (PW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/instr_prefetch_unit.sv
// Instruction prefetch unit: issues in-order fetches, queues responses for decode,
// handles execute redirects by dropping in-flight responses, and halts on a fault.
module instr_prefetch_unit
    import fetch_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        imem_rsp_err,
    output logic [31:0] komut,
    output logic [31:0] pc,
    output logic        komut_valid,
    input  logic        komut_ready,
    input  logic        pc_update,
    input  logic [31:0] pc_new,
    output logic        hata
);
    localparam int            CW     = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] ZERO   = {CW{1'b0}};
    localparam logic [CW:0]   DEPTH_L = (CW+1)'(DEPTH);

    fetch_state_t  r_state;
    logic          r_hata;
    logic          r_req_valid;
    logic [31:0]   r_fpc;
    logic [31:0]   r_target;
    logic          r_stale;
    logic [CW-1:0] r_out;
    logic [CW-1:0] r_drop;

    fetch_entry_t  w_head;
    fetch_entry_t  w_entry;
    logic [$bits(fetch_entry_t)-1:0] w_q_data;
    logic [CW-1:0] w_q_count;
    logic [CW-1:0] w_t_count;
    logic [31:0]   w_tag;
    logic          w_q_empty, w_q_full, w_t_empty, w_t_full;
    logic          w_run, w_accept, w_redirect, w_push, w_pop, w_head_ok, w_fault;
    logic [CW-1:0] w_out_next, w_count_next, w_drop_next;
    logic [31:0]   w_fpc_next;
    logic          w_stale_next;
    logic          w_unused;

    assign w_run      = (r_state == RUN);
    assign w_accept   = r_req_valid && imem_req_ready;
    assign w_redirect = pc_update && w_run;
    assign w_push     = imem_rsp_valid && (r_drop == ZERO) && w_run && !w_redirect;
    assign w_head     = fetch_entry_t'(w_q_data);
    assign w_head_ok  = !w_q_empty && !w_head.err && w_run;
    assign w_pop      = w_head_ok && komut_ready;
    assign w_fault    = w_run && ((w_redirect && misaligned(pc_new)) ||
                                  (!w_q_empty && w_head.err));
    assign w_entry    = '{err: imem_rsp_err, addr: w_tag, instr: imem_rsp_data};
    assign w_unused   = &{1'b0, w_q_full, w_t_full, w_t_empty, w_t_count};

    sync_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_queue (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (w_redirect),
        .i_data  (w_entry),
        .o_data  (w_q_data),
        .o_full  (w_q_full),
        .o_empty (w_q_empty),
        .o_count (w_q_count)
    );

    // Tag queue remembers each accepted address so responses can be labelled in order.
    sync_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_tags (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_accept),
        .i_pop   (imem_rsp_valid),
        .i_flush (1'b0),
        .i_data  (r_fpc),
        .o_data  (w_tag),
        .o_full  (w_t_full),
        .o_empty (w_t_empty),
        .o_count (w_t_count)
    );

    // Next-state for counters and fetch address; a stalled request keeps its address.
    always_comb begin
        w_out_next = r_out + {{(CW-1){1'b0}}, w_accept} - {{(CW-1){1'b0}}, imem_rsp_valid};
        if (w_redirect) begin
            w_count_next = ZERO;
            w_drop_next  = w_out_next;
            w_stale_next = r_req_valid && !imem_req_ready;
            w_fpc_next   = w_stale_next ? r_fpc : pc_new;
        end else begin
            w_count_next = w_q_count + {{(CW-1){1'b0}}, w_push} - {{(CW-1){1'b0}}, w_pop};
            w_drop_next  = r_drop - {{(CW-1){1'b0}}, (imem_rsp_valid && r_drop != ZERO)}
                                  + {{(CW-1){1'b0}}, (w_accept && r_stale)};
            w_stale_next = w_accept ? 1'b0 : r_stale;
            if (w_accept) begin
                w_fpc_next = r_stale ? r_target : r_fpc + INSTR_BYTES;
            end else begin
                w_fpc_next = r_fpc;
            end
        end
    end

    // Datapath registers and the registered request-valid.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_fpc       <= RESET_PC;
            r_target    <= RESET_PC;
            r_stale     <= 1'b0;
            r_out       <= ZERO;
            r_drop      <= ZERO;
            r_req_valid <= 1'b0;
        end else begin
            r_fpc       <= w_fpc_next;
            r_stale     <= w_stale_next;
            r_out       <= w_out_next;
            r_drop      <= w_drop_next;
            r_req_valid <= w_run && !w_fault &&
                           (({1'b0, w_count_next} + {1'b0, w_out_next}) < DEPTH_L);
            if (w_redirect) r_target <= pc_new;
        end
    end

    // Fault FSM: only reset leaves HALT.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= RUN;
            r_hata  <= 1'b0;
        end else begin
            case (r_state)
                RUN: begin
                    if (w_fault) begin
                        r_state <= HALT;
                        r_hata  <= 1'b1;
                    end
                end
                HALT: begin
                    r_state <= HALT;
                    r_hata  <= 1'b1;
                end
                default: begin
                    r_state <= HALT;
                    r_hata  <= 1'b1;
                end
            endcase
        end
    end

    assign imem_req_valid = r_req_valid;
    assign imem_req_addr  = r_fpc;
    assign komut_valid    = w_head_ok;
    assign komut          = w_head_ok ? w_head.instr : 32'h0000_0000;
    assign pc             = w_head_ok ? w_head.addr  : 32'h0000_0000;
    assign hata           = r_hata;

endmodule

// File: tb/tb_instr_prefetch_unit.sv
// Directed bench for instr_prefetch_unit with a small in-order memory responder.
module tb_instr_prefetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'h0;
    logic        imem_rsp_err = 1'b0;
    logic [31:0] komut;
    logic [31:0] pc;
    logic        komut_valid;
    logic        komut_ready = 1'b1;
    logic        pc_update = 1'b0;
    logic [31:0] pc_new = 32'h0;
    logic        hata;

    logic        rsp_en = 1'b1;
    logic        err_en = 1'b0;
    logic [31:0] err_addr = 32'h0;

    logic [31:0] pend[$];
    logic [31:0] issued[$];
    logic [31:0] delivered[$];

    int n_chk = 0;
    int n_err = 0;
    int n0;

    instr_prefetch_unit #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .imem_rsp_err   (imem_rsp_err),
        .komut          (komut),
        .pc             (pc),
        .komut_valid    (komut_valid),
        .komut_ready    (komut_ready),
        .pc_update      (pc_update),
        .pc_new         (pc_new),
        .hata           (hata)
    );

    always #5 clk = ~clk;

    // Memory responder and delivery monitor, evaluated 1ns before each rising edge.
    always begin
        @(negedge clk);
        #4;
        if (!reset) begin
            pend.delete();
            imem_rsp_valid = 1'b0;
            imem_rsp_err   = 1'b0;
        end else begin
            if (komut_valid && komut_ready) delivered.push_back(pc);
            imem_rsp_valid = 1'b0;
            imem_rsp_err   = 1'b0;
            if (rsp_en && pend.size() > 0) begin
                logic [31:0] a;
                a = pend.pop_front();
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = 32'h0000_0013;
                imem_rsp_err   = err_en && (a == err_addr);
            end
            if (imem_req_valid && imem_req_ready) begin
                pend.push_back(imem_req_addr);
                issued.push_back(imem_req_addr);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        reset     = 1'b0;
        pc_update = 1'b0;
        repeat (3) @(negedge clk);
        delivered.delete();
        issued.delete();
        check("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check("rst_req_addr", imem_req_addr, 32'h0);
        check("rst_komut_valid", 32'(komut_valid), 32'd0);
        check("rst_hata", 32'(hata), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        check("rel_req_valid", 32'(imem_req_valid), 32'd1);
        check("rel_req_addr", imem_req_addr, 32'h0);
    endtask

    task automatic wait_deliv(input string tag, input int n);
        for (int i = 0; i < 60 && delivered.size() < n; i++) @(negedge clk);
        check(tag, 32'(delivered.size() >= n), 32'd1);
    endtask

    task automatic wait_issued(input string tag, input int n);
        for (int i = 0; i < 60 && issued.size() < n; i++) @(negedge clk);
        check(tag, 32'(issued.size() >= n), 32'd1);
    endtask

    initial begin
        // Streaming: one instruction per cycle from cycle 3.
        do_reset();
        for (int c = 2; c <= 9; c++) begin
            @(negedge clk);
            check("stream_valid", 32'(komut_valid), 32'(c >= 3));
            if (c >= 3) begin
                check("stream_pc", pc, 32'(4 * (c - 3)));
                check("stream_komut", komut, 32'h0000_0013);
            end
        end
        // Redirect with a non-empty queue.
        pc_update = 1'b1;
        pc_new    = 32'h0000_0200;
        @(negedge clk);
        pc_update = 1'b0;
        check("redir_flush", 32'(komut_valid), 32'd0);
        check("redir_addr", imem_req_addr, 32'h0000_0200);
        n0 = delivered.size();
        wait_deliv("redir_cnt", n0 + 2);
        check("redir_pc0", delivered[n0], 32'h0000_0200);
        check("redir_pc1", delivered[n0 + 1], 32'h0000_0204);

        // Decode stalled: budget of 4 requests.
        komut_ready = 1'b0;
        do_reset();
        repeat (12) @(negedge clk);
        check("stall_issued", 32'(issued.size()), 32'd4);
        check("stall_req_valid", 32'(imem_req_valid), 32'd0);
        check("stall_head_pc", pc, 32'h0);
        komut_ready = 1'b1;
        wait_deliv("stall_cnt", 4);
        check("stall_pc0", delivered[0], 32'h0);
        check("stall_pc1", delivered[1], 32'h4);
        check("stall_pc2", delivered[2], 32'h8);
        check("stall_pc3", delivered[3], 32'hC);
        wait_issued("resume_cnt", 5);
        check("resume_addr", issued[4], 32'h10);

        // Two in flight plus a stalled request, then redirect.
        rsp_en = 1'b0;
        do_reset();
        @(negedge clk);
        @(negedge clk);
        imem_req_ready = 1'b0;
        @(negedge clk);
        check("hold_valid", 32'(imem_req_valid), 32'd1);
        check("hold_addr", imem_req_addr, 32'h8);
        pc_update = 1'b1;
        pc_new    = 32'h0000_0100;
        @(negedge clk);
        pc_update = 1'b0;
        check("hold_flush", 32'(komut_valid), 32'd0);
        check("hold_addr_kept", imem_req_addr, 32'h8);
        imem_req_ready = 1'b1;
        rsp_en         = 1'b1;
        wait_deliv("drop_cnt", 2);
        check("drop_pc0", delivered[0], 32'h100);
        check("drop_pc1", delivered[1], 32'h104);
        check("drop_iss2", issued[2], 32'h8);
        check("drop_iss3", issued[3], 32'h100);

        // Misaligned redirect halts the unit.
        do_reset();
        repeat (6) @(negedge clk);
        pc_update = 1'b1;
        pc_new    = 32'h0000_0102;
        @(negedge clk);
        pc_update = 1'b0;
        check("mis_hata", 32'(hata), 32'd1);
        check("mis_valid", 32'(komut_valid), 32'd0);
        n0 = issued.size();
        repeat (6) @(negedge clk);
        check("mis_no_req", 32'(issued.size()), 32'(n0));
        check("mis_req_valid", 32'(imem_req_valid), 32'd0);
        check("mis_valid_late", 32'(komut_valid), 32'd0);
        check("mis_hata_sticky", 32'(hata), 32'd1);

        // Bus error on the fetch of 0x8.
        err_en   = 1'b1;
        err_addr = 32'h8;
        do_reset();
        for (int i = 0; i < 30 && !hata; i++) @(negedge clk);
        check("err_hata", 32'(hata), 32'd1);
        check("err_cnt", 32'(delivered.size()), 32'd2);
        check("err_pc0", delivered[0], 32'h0);
        check("err_pc1", delivered[1], 32'h4);
        check("err_valid", 32'(komut_valid), 32'd0);
        err_en = 1'b0;

        // Fetch address wrap.
        do_reset();
        repeat (3) @(negedge clk);
        pc_update = 1'b1;
        pc_new    = 32'hFFFF_FFFC;
        @(negedge clk);
        pc_update = 1'b0;
        n0 = delivered.size();
        wait_deliv("wrap_cnt", n0 + 2);
        check("wrap_pc0", delivered[n0], 32'hFFFF_FFFC);
        check("wrap_pc1", delivered[n0 + 1], 32'h0);
        check("wrap_hata", 32'(hata), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
